// File: rtl/hermes_inbuffer.sv
// Hermes router input buffer: flit FIFO plus a packet FSM that requests a route and streams header, size and payload.
// Optional macro HERMES_INBUF_OCCUPANCY_EN adds occupancy_o, the current FIFO flit count.
module hermes_inbuffer #(
   parameter int FLIT_SIZE   = 16,
   parameter int BUFFER_SIZE = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rx_i,
   input  logic [FLIT_SIZE-1:0] data_i,
   output logic                 credit_o,
   output logic                 req_o,
   output logic [FLIT_SIZE-1:0] header_o,
   input  logic                 ack_h_i,
   output logic                 sending_o,
   output logic                 tx_o,
   output logic [FLIT_SIZE-1:0] data_o,
   input  logic                 credit_i
`ifdef HERMES_INBUF_OCCUPANCY_EN
   ,
   output logic [$clog2(BUFFER_SIZE):0] occupancy_o
`endif
);

   localparam int PTR_W = $clog2(BUFFER_SIZE);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_SIZE);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_HEADER  = 3'd2,
      ST_SIZE    = 3'd3,
      ST_PAYLOAD = 3'd4,
      ST_END     = 3'd5
   } state_t;

   logic [FLIT_SIZE-1:0] mem_r [BUFFER_SIZE];
   logic [PTR_W-1:0]     wr_ptr_r;
   logic [PTR_W-1:0]     rd_ptr_r;
   logic [CNT_W-1:0]     count_r;
   logic [CNT_W-1:0]     count_nxt_s;
   state_t               state_r;
   state_t               state_nxt_s;
   logic [FLIT_SIZE-1:0] pay_cnt_r;
   logic [FLIT_SIZE-1:0] pay_cnt_nxt_s;
   logic                 credit_r;
   logic                 req_r;
   logic                 sending_r;
   logic                 tx_r;
   logic                 wr_en_s;
   logic                 pop_s;
   logic [FLIT_SIZE-1:0] head_s;

   assign head_s  = mem_r[rd_ptr_r];
   assign wr_en_s = rx_i & credit_r;
   assign pop_s   = tx_r & credit_i;

   // Next FIFO occupancy from the write/pop pair of this cycle.
   always_comb begin
      count_nxt_s = count_r;
      case ({wr_en_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_W'(1);
         2'b01:   count_nxt_s = count_r - CNT_W'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk_i) begin
      if (!rst_i && wr_en_s) begin
         mem_r[wr_ptr_r] <= data_i;
      end
   end

   // FIFO pointers and count; power-of-two depth makes pointer wrap free.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_nxt_s;
      end
   end

   // Packet FSM next state; the size flit loads the payload counter.
   always_comb begin
      state_nxt_s   = state_r;
      pay_cnt_nxt_s = pay_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (count_r != CNT_W'(0)) state_nxt_s = ST_REQ;
            else                      state_nxt_s = ST_IDLE;
         end
         ST_REQ: begin
            if (ack_h_i) state_nxt_s = ST_HEADER;
            else         state_nxt_s = ST_REQ;
         end
         ST_HEADER: begin
            if (pop_s) state_nxt_s = ST_SIZE;
            else       state_nxt_s = ST_HEADER;
         end
         ST_SIZE: begin
            if (pop_s) begin
               pay_cnt_nxt_s = head_s;
               if (head_s == FLIT_SIZE'(0)) state_nxt_s = ST_END;
               else                         state_nxt_s = ST_PAYLOAD;
            end else begin
               state_nxt_s = ST_SIZE;
            end
         end
         ST_PAYLOAD: begin
            if (pop_s) begin
               pay_cnt_nxt_s = pay_cnt_r - FLIT_SIZE'(1);
               if (pay_cnt_r == FLIT_SIZE'(1)) state_nxt_s = ST_END;
               else                            state_nxt_s = ST_PAYLOAD;
            end else begin
               state_nxt_s = ST_PAYLOAD;
            end
         end
         ST_END:  state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, counter and output flags, all registered from next-cycle values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r   <= ST_IDLE;
         pay_cnt_r <= '0;
         credit_r  <= 1'b1;
         req_r     <= 1'b0;
         sending_r <= 1'b0;
         tx_r      <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         pay_cnt_r <= pay_cnt_nxt_s;
         credit_r  <= (count_nxt_s != FULL_CNT);
         req_r     <= (state_nxt_s == ST_REQ);
         sending_r <= (state_nxt_s inside {ST_HEADER, ST_SIZE, ST_PAYLOAD, ST_END});
         tx_r      <= (state_nxt_s inside {ST_HEADER, ST_SIZE, ST_PAYLOAD}) &&
                      (count_nxt_s != CNT_W'(0));
      end
   end

   assign credit_o  = credit_r;
   assign req_o     = req_r;
   assign sending_o = sending_r;
   assign tx_o      = tx_r;
   assign data_o    = head_s;
   assign header_o  = head_s;

`ifdef HERMES_INBUF_OCCUPANCY_EN
   assign occupancy_o = count_r;
`endif

endmodule

// File: tb/tb_hermes_inbuffer.sv
// Bench for hermes_inbuffer: packet-level model (queue plus phase/flit counts) checked every cycle, plus literal expectations.
module tb_hermes_inbuffer;
   localparam int DEPTH  = 8;
   localparam int P_IDLE = 0;
   localparam int P_REQ  = 1;
   localparam int P_XFER = 2;
   localparam int P_END  = 3;

   logic        clk_i;
   logic        rst_i;
   logic        rx_i;
   logic [15:0] data_i;
   logic        credit_o;
   logic        req_o;
   logic [15:0] header_o;
   logic        ack_h_i;
   logic        sending_o;
   logic        tx_o;
   logic [15:0] data_o;
   logic        credit_i;
`ifdef HERMES_INBUF_OCCUPANCY_EN
   logic [3:0]  occupancy_o;
`endif

   hermes_inbuffer #(.FLIT_SIZE(16), .BUFFER_SIZE(DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .data_i(data_i),
      .credit_o(credit_o), .req_o(req_o), .header_o(header_o), .ack_h_i(ack_h_i),
      .sending_o(sending_o), .tx_o(tx_o), .data_o(data_o), .credit_i(credit_i)
`ifdef HERMES_INBUF_OCCUPANCY_EN
      , .occupancy_o(occupancy_o)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_send   = 0;
   logic [15:0] m_q[$];
   int          m_phase   = P_IDLE;
   int          m_sent    = 0;
   int          m_total   = 0;
   int          m_req_age = 0;
   bit          m_wrote   = 1'b0;
   logic [15:0] src_q[$];
   logic [15:0] tx_log[$];
   logic [15:0] exp_q[$];
   bit          allow_rx = 1'b0;
   bit          cred     = 1'b0;
   bit          auto_ack = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Packet-level model: a packet is header + size + size payloads after a grant, then one idle-out cycle.
   task automatic model_step();
      bit          pre_credit;
      bit          pop;
      logic [15:0] f;
      if (rst_i) begin
         m_q.delete();
         m_phase   = P_IDLE;
         m_sent    = 0;
         m_total   = 0;
         m_req_age = 0;
         m_wrote   = 1'b0;
      end else begin
         pre_credit = (m_q.size() < DEPTH);
         pop        = (m_phase == P_XFER) && (m_q.size() > 0) && credit_i;
         m_wrote    = rx_i && pre_credit;
         f          = (m_q.size() > 0) ? m_q[0] : 16'h0000;
         case (m_phase)
            P_IDLE: if (m_q.size() > 0) begin m_phase = P_REQ; m_req_age = 0; end
            P_REQ: begin
               if (ack_h_i) begin m_phase = P_XFER; m_sent = 0; m_total = 32'h7fffffff; end
               else m_req_age++;
            end
            P_XFER: begin
               if (pop) begin
                  m_sent++;
                  if (m_sent == 2) m_total = 2 + int'(f);
                  if (m_sent == m_total) m_phase = P_END;
               end
            end
            default: m_phase = P_IDLE;
         endcase
         if (pop) void'(m_q.pop_front());
         if (m_wrote) m_q.push_back(data_i);
      end
   endtask

   task automatic compare_cycle();
      bit exp_tx;
      exp_tx = (m_phase == P_XFER) && (m_q.size() > 0);
      check("credit_o", 32'(credit_o), 32'(m_q.size() < DEPTH));
      check("req_o", 32'(req_o), 32'(m_phase == P_REQ));
      check("sending_o", 32'(sending_o), 32'((m_phase == P_XFER) || (m_phase == P_END)));
      check("tx_o", 32'(tx_o), 32'(exp_tx));
      if (m_phase == P_REQ) check("header_o", 32'(header_o), 32'(m_q[0]));
      if (exp_tx) check("data_o", 32'(data_o), 32'(m_q[0]));
`ifdef HERMES_INBUF_OCCUPANCY_EN
      check("occupancy_o", 32'(occupancy_o), 32'(m_q.size()));
`endif
      if (sending_o) n_send++;
   endtask

   // Inputs change at the negedge; the model advances with them; outputs are compared at the next negedge.
   task automatic tick();
      rx_i     = allow_rx && (src_q.size() > 0);
      data_i   = rx_i ? src_q[0] : 16'h0000;
      ack_h_i  = auto_ack && (m_phase == P_REQ) && (m_req_age >= 1);
      credit_i = cred;
      if (tx_o && credit_i) tx_log.push_back(data_o);
      model_step();
      if (m_wrote) void'(src_q.pop_front());
      @(posedge clk_i);
      @(negedge clk_i);
      compare_cycle();
   endtask

   task automatic check_log(input string name);
      check({name, "_len"}, 32'(tx_log.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         check(name, (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hxxxxxxxx, 32'(exp_q[i]));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      rst_i = 1'b1; rx_i = 1'b0; data_i = 16'h0000; ack_h_i = 1'b0; credit_i = 1'b0;
      @(negedge clk_i);
      tick(); tick();
      check("rst_credit", 32'(credit_o), 32'd1);
      check("rst_req", 32'(req_o), 32'd0);
      check("rst_sending", 32'(sending_o), 32'd0);
      check("rst_tx", 32'(tx_o), 32'd0);
      rst_i = 1'b0;

      // single packet, req one cycle after header write
      cred = 1'b1; auto_ack = 1'b1; allow_rx = 1'b1; tx_log.delete(); n_send = 0;
      src_q = '{16'h0011, 16'h0002, 16'haaaa, 16'hbbbb};
      tick(); check("req_lat0", 32'(req_o), 32'd0);
      tick(); check("req_lat1", 32'(req_o), 32'd1);
      repeat (12) tick();
      exp_q = '{16'h0011, 16'h0002, 16'haaaa, 16'hbbbb};
      check_log("pkt1");
      check("pkt1_send_cycles", 32'(n_send), 32'd5);
      check("pkt1_sending_low", 32'(sending_o), 32'd0);

      // zero-size packet
      tx_log.delete(); n_send = 0;
      src_q = '{16'h0022, 16'h0000};
      repeat (12) tick();
      exp_q = '{16'h0022, 16'h0000};
      check_log("zero");
      check("zero_send_cycles", 32'(n_send), 32'd3);

      // back-to-back packets
      tx_log.delete();
      src_q = '{16'h0033, 16'h0001, 16'hc001, 16'h0044, 16'h0000};
      repeat (20) tick();
      exp_q = '{16'h0033, 16'h0001, 16'hc001, 16'h0044, 16'h0000};
      check_log("b2b");

      // downstream stall mid-payload
      tx_log.delete();
      src_q = '{16'h0055, 16'h0003, 16'h1111, 16'h2222, 16'h3333};
      b = 0;
      while (tx_log.size() < 3 && b < 40) begin tick(); b++; end
      check("stall_reach", 32'(tx_log.size()), 32'd3);
      cred = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_tx", 32'(tx_o), 32'd1);
         check("stall_data", 32'(data_o), 32'h2222);
      end
      cred = 1'b1;
      repeat (10) tick();
      exp_q = '{16'h0055, 16'h0003, 16'h1111, 16'h2222, 16'h3333};
      check_log("stall");
      check("stall_sending_low", 32'(sending_o), 32'd0);

      // fill to full with no grant and no downstream credit
      cred = 1'b0; auto_ack = 1'b0;
      src_q = '{16'h0066, 16'h0010, 16'h0101, 16'h0102, 16'h0103,
                16'h0104, 16'h0105, 16'h0106, 16'h0107};
      repeat (7) tick();
      check("full_c7", 32'(credit_o), 32'd1);
      tick(); check("full_c8", 32'(credit_o), 32'd0);
      tick(); check("full_c9", 32'(credit_o), 32'd0);
      check("full_model_cnt", 32'(m_q.size()), 32'd8);
      allow_rx = 1'b0; src_q.delete(); auto_ack = 1'b1;
      b = 0;
      while (m_phase != P_XFER && b < 10) begin tick(); b++; end
      check("full_grant_tx", 32'(tx_o), 32'd1);
      cred = 1'b1; tick(); cred = 1'b0;
      check("full_pop_credit", 32'(credit_o), 32'd1);

      // reset mid-payload with three flits queued
      cred = 1'b1;
      repeat (4) tick();
      cred = 1'b0;
      check("pre_rst_queued", 32'(m_q.size()), 32'd3);
      check("pre_rst_sending", 32'(sending_o), 32'd1);
      rst_i = 1'b1; tick();
      check("mid_rst_credit", 32'(credit_o), 32'd1);
      check("mid_rst_sending", 32'(sending_o), 32'd0);
      check("mid_rst_tx", 32'(tx_o), 32'd0);
      check("mid_rst_req", 32'(req_o), 32'd0);
`ifdef HERMES_INBUF_OCCUPANCY_EN
      check("mid_rst_occ", 32'(occupancy_o), 32'd0);
`endif
      rst_i = 1'b0; tick();
      check("post_rst_req", 32'(req_o), 32'd0);
      check("post_rst_sending", 32'(sending_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
